// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB initiator. Accepts one command at a time on a valid/ready interface,
// runs it as an APB SETUP + ACCESS transfer (ACCESS stretched while PREADY is
// low) and reports completion on a single-cycle rsp_valid strobe.
//
// Optional feature macro: APB_TIMEOUT_EN
//   Defined   : an ACCESS phase that sees PREADY low for TIMEOUT_CYCLES cycles
//               is aborted and reported with rsp_err = 1.
//   Undefined : ACCESS waits for PREADY indefinitely; rsp_err is tied 0.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata command payload, captured on acceptance
//   rsp_valid            one-cycle completion strobe
//   rsp_write/rdata/err  completion info, held until the next response
//   PSEL..PWDATA         APB request outputs (all registered)
//   PRDATA, PREADY       APB responder inputs
//
// state  | meaning
// IDLE   | no transfer; cmd_ready = 1; PSEL = PENABLE = 0
// SETUP  | first APB cycle: PSEL = 1, PENABLE = 0 (always one cycle)
// ACCESS | PSEL = PENABLE = 1; stays here while PREADY is low
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   xfer_done;
    logic   xfer_abort;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    assign cmd_ready = (state == IDLE);
    assign xfer_done = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of PREADY-low ACCESS cycles already seen, so
    // the cycle that would bring it to TIMEOUT_CYCLES is the aborting one.
    // PREADY high in that same cycle takes priority (xfer_done).
    assign xfer_abort = (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_err <= 1'b0;
        end else if (xfer_done) begin
            rsp_err <= 1'b0;
        end else if (xfer_abort) begin
            rsp_err <= 1'b1;
        end
    end
`else
    assign xfer_abort = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (xfer_done || xfer_abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // APB strobes are registered copies of the upcoming state so they line up
    // with it cycle for cycle and clear asynchronously with the reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            PSEL    <= (state_nxt != IDLE);
            PENABLE <= (state_nxt == ACCESS);
            if (state == IDLE && cmd_valid) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= xfer_done || xfer_abort;
            if (xfer_done) begin
                rsp_write <= PWRITE;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (xfer_abort) begin
                rsp_write <= PWRITE;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master. A transaction-level model tracks how many
// edges have passed since a command was accepted and derives the expected APB
// strobes and response from that age and the PREADY/PRDATA the bench drives.
// A compare process checks every DUT output against the model on each falling
// edge; directed tests add literal latency/data expectations.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rsp_count = 0;

    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) if (PRESETn && rsp_valid) rsp_count <= rsp_count + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age = edges since the accepting edge: 1 = select phase, >=2 = enable
    // phase; access cycles completed so far = m_age - 1.
    logic          m_busy;
    int            m_age;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rv;
    logic          m_rw;
    logic          m_err;
    logic [DW-1:0] m_rdata;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_busy <= 1'b0; m_age <= 0; m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_rv <= 1'b0; m_rw <= 1'b0; m_err <= 1'b0; m_rdata <= '0;
        end else begin
            m_rv <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy  <= 1'b1;
                    m_age   <= 1;
                    m_write <= cmd_write;
                    m_addr  <= cmd_addr;
                    m_wdata <= cmd_wdata;
                end
            end else if (m_age < 2) begin
                m_age <= 2;
            end else if (PREADY) begin
                m_busy  <= 1'b0;
                m_rv    <= 1'b1;
                m_rw    <= m_write;
                m_rdata <= m_write ? '0 : PRDATA;
                m_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            end else if (m_age - 1 >= TO) begin
                m_busy  <= 1'b0;
                m_rv    <= 1'b1;
                m_rw    <= m_write;
                m_rdata <= '0;
                m_err   <= 1'b1;
`endif
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn) begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("psel",      PSEL,      m_busy);
            chk("penable",   PENABLE,   m_busy && m_age >= 2);
            chk("pwrite",    PWRITE,    m_write);
            chk("paddr",     PADDR,     m_addr);
            chk("pwdata",    PWDATA,    m_wdata);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_write", rsp_write, m_rw);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err",   rsp_err,   m_err);
        end
    end

    // ---------------- APB responder ----------------
    int            waits_cfg = 0;
    logic [DW-1:0] rd_cfg    = '0;

    initial begin
        int acc_n;
        acc_n  = 0;
        PREADY = 1'b0;
        PRDATA = 32'hBAD0_BAD0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                if (acc_n < waits_cfg) begin
                    PREADY = 1'b0;
                    PRDATA = 32'hDEAD_BEEF;
                    acc_n++;
                end else begin
                    PREADY = 1'b1;
                    PRDATA = rd_cfg;
                end
            end else begin
                PREADY = 1'b0;
                PRDATA = 32'hBAD0_BAD0;
                acc_n  = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept(output int acc_c, output int n);
        bit ok;
        ok = 0;
        n  = 0;
        acc_c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            n++;
            if (cmd_ready) begin
                ok = 1;
                acc_c = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for 100 cycles, required 1");
        end
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_c);
        int n;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        wait_accept(acc_c, n);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_c, output int psel_n);
        bit ok;
        ok = 0;
        rsp_c  = 0;
        psel_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                ok = 1;
                rsp_c = cyc;
                break;
            end
            if (PSEL) psel_n++;
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 for 200 cycles, required 1");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int a_c, r_c, p_n, n, snap;
        PRESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // reset, with a command presented that must be ignored
        #2 PRESETn = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_0000; cmd_wdata = 32'h1;
        repeat (3) @(negedge PCLK);
        chk("rst_psel",      PSEL,      1'b0);
        chk("rst_penable",   PENABLE,   1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_paddr",     PADDR,     32'h0);
        cmd_valid = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // write, zero wait states
        waits_cfg = 0;
        send(1'b1, 32'h0000_0004, 32'h0000_00A5, a_c);
        wait_rsp(r_c, p_n);
        chk("wr0_latency", r_c - a_c, 3);
        chk("wr0_psel_cycles", p_n, 2);
        chk("wr0_rsp_write", rsp_write, 1'b1);
        chk("wr0_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr0_rsp_err", rsp_err, 1'b0);
        chk("wr0_paddr", PADDR, 32'h4);
        chk("wr0_pwdata", PWDATA, 32'hA5);

        // read, three wait states
        waits_cfg = 3; rd_cfg = 32'h0000_005A;
        send(1'b0, 32'h0000_0008, 32'h0, a_c);
        wait_rsp(r_c, p_n);
        chk("rd3_latency", r_c - a_c, 6);
        chk("rd3_psel_cycles", p_n, 5);
        chk("rd3_rsp_write", rsp_write, 1'b0);
        chk("rd3_rsp_rdata", rsp_rdata, 32'h5A);

        // back-pressure: second command held until the first completes
        waits_cfg = 1; rd_cfg = 32'h0000_0077;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h11;
        wait_accept(a_c, n);
        @(posedge PCLK); #1;
        cmd_write = 1'b0; cmd_addr = 32'h14; cmd_wdata = 32'h0;
        wait_accept(a_c, n);
        chk("bp_wait_cycles", n, 4);
        chk("bp_on_rsp", rsp_valid, 1'b1);
        chk("bp_gap_psel", PSEL, 1'b0);
        @(posedge PCLK); #1 cmd_valid = 1'b0;
        wait_rsp(r_c, p_n);
        chk("bp_rd_latency", r_c - a_c, 4);
        chk("bp_rd_rdata", rsp_rdata, 32'h77);

        // address/data stability while the requester changes its inputs
        waits_cfg = 3;
        send(1'b1, 32'h0000_0020, 32'h0000_1234, a_c);
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK); #1;
            cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'b0;
        end
        wait_rsp(r_c, p_n);
        chk("stab_latency", r_c - a_c, 6);
        chk("stab_paddr", PADDR, 32'h20);
        chk("stab_pwdata", PWDATA, 32'h1234);
        chk("stab_pwrite", PWRITE, 1'b1);

        // reset during an ACCESS wait state
        waits_cfg = 20;
        send(1'b0, 32'h0000_0030, 32'h0, a_c);
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        chk("mrst_psel", PSEL, 1'b0);
        chk("mrst_penable", PENABLE, 1'b0);
        chk("mrst_rsp_valid", rsp_valid, 1'b0);
        snap = rsp_count;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);
        chk("mrst_cmd_ready", cmd_ready, 1'b1);
        chk("mrst_no_rsp", rsp_count, snap);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after TO access cycles
        waits_cfg = 1000;
        send(1'b0, 32'h0000_0040, 32'h0, a_c);
        wait_rsp(r_c, p_n);
        chk("to_latency", r_c - a_c, 6);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        // PREADY rises on the limit cycle: normal completion
        waits_cfg = 3; rd_cfg = 32'h0000_0099;
        send(1'b0, 32'h0000_0044, 32'h0, a_c);
        wait_rsp(r_c, p_n);
        chk("to_edge_latency", r_c - a_c, 6);
        chk("to_edge_rsp_err", rsp_err, 1'b0);
        chk("to_edge_rdata", rsp_rdata, 32'h99);
`else
        // without the timeout a long wait simply completes
        waits_cfg = 10; rd_cfg = 32'h0000_0099;
        send(1'b0, 32'h0000_0044, 32'h0, a_c);
        wait_rsp(r_c, p_n);
        chk("long_latency", r_c - a_c, 13);
        chk("long_rsp_err", rsp_err, 1'b0);
        chk("long_rdata", rsp_rdata, 32'h99);
`endif

        repeat (3) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns a simple single-outstanding command interface into APB SETUP/ACCESS transfers, with wait-state support via PREADY.
- Drives the APB slave port of the UART block (and any other APB responder on the bus) from an on-chip controller or testbench sequencer.
- Returns read data and completion status on a one-cycle response strobe.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data paths.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles with PREADY low before abort. Used only with APB_TIMEOUT_EN; legal range 1..65535.

Ports:
- PCLK  input  1  system clock, all logic on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master can accept a command; high only in IDLE.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_write  output  1  type of the completed transfer.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and aborted transfers.
- rsp_err  output  1  transfer aborted by timeout; constant 0 without APB_TIMEOUT_EN.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready / wait-state control.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_write, rsp_rdata, rsp_err and the timeout counter all 0.
  - cmd_valid is ignored while PRESETn is low.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered; cmd_ready = (state == IDLE).
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - On cmd_valid & cmd_ready: capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA; next state SETUP.
  - Outside a transfer, PADDR, PWDATA and PWRITE hold their last values.
- SETUP: exactly one cycle with PSEL = 1, PENABLE = 0; next state ACCESS unconditionally.
- ACCESS: PSEL = 1, PENABLE = 1; PADDR, PWDATA and PWRITE stay stable.
  - PREADY low: remain in ACCESS (wait state).
  - PREADY high: transfer completes. Next cycle:
    - state IDLE, PSEL = 0, PENABLE = 0.
    - rsp_valid = 1 for exactly one cycle, rsp_write = PWRITE, rsp_err = 0.
    - rsp_rdata = PRDATA sampled on the completing edge for reads, 0 for writes.
- Latency: command accepted at edge N → SETUP at N+1 → ACCESS at N+2 → with zero wait states, rsp_valid at N+3 and cmd_ready high again at N+3.
  - Each PREADY-low ACCESS cycle adds one cycle.
  - No back-to-back transfers: at least one IDLE cycle (PSEL = 0) between transfers.
- Response interface: no backpressure; the consumer must sample rsp_* on the rsp_valid cycle. rsp_rdata, rsp_write and rsp_err hold until the next response.
- cmd_valid during SETUP or ACCESS: ignored (cmd_ready = 0); the command is not lost if the requester holds it.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously), no response is generated, and the FSM restarts in IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter (width ceil(log2(TIMEOUT_CYCLES+1))) clears on entry to ACCESS and increments on each ACCESS cycle with PREADY low.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still low: next cycle PSEL = 0, PENABLE = 0, state IDLE, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - If PREADY is high on the same cycle the limit is reached, PREADY wins and the transfer completes normally with rsp_err = 0.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY; rsp_err is tied 0.

Test Plan:
- Write, zero wait: cmd write addr 0x0000_0004 data 0x0000_00A5, PREADY = 1 → SETUP then ACCESS with PADDR = 0x4, PWDATA = 0xA5, PWRITE = 1; rsp_valid at N+3, rsp_write = 1, rsp_rdata = 0, rsp_err = 0.
- Read, 3 wait states: cmd read addr 0x0000_0008, PREADY low 3 ACCESS cycles then high with PRDATA = 0x0000_005A → PSEL held 5 cycles total; rsp_valid at N+6, rsp_rdata = 0x5A.
- Back-pressure: hold cmd_valid = 1 with two queued commands → second command accepted only after rsp_valid of the first; PSEL = 0 for ≥1 cycle between transfers.
- Address/data stability: change cmd_addr and cmd_wdata during ACCESS wait states → PADDR and PWDATA remain at the captured values.
- Reset mid-ACCESS: assert PRESETn low during a wait state → PSEL, PENABLE and rsp_valid are 0 before the next PCLK edge; after release, cmd_ready = 1 and no spurious response.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 4, PREADY stuck 0 → abort after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0. Rerun with PREADY rising on the 4th cycle → rsp_err = 0.
